mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_defs.sv | 25 ++
 rtl/mdu_step.sv | 39 +++
 rtl/mul_div_unit.sv | 159 +++++++++++++++
 tb/tb_mul_div_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_defs.sv
`default_nettype none
// ============================================================================
// Module      : mdu_defs
// Description : Shared op codes, FSM state encodings and step modes for the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_defs;

    localparam logic [2:0] c_opMult  = 3'd0;
    localparam logic [2:0] c_opMultu = 3'd1;
    localparam logic [2:0] c_opDiv   = 3'd2;
    localparam logic [2:0] c_opDivu  = 3'd3;
    localparam logic [2:0] c_opMthi  = 3'd4;
    localparam logic [2:0] c_opMtlo  = 3'd5;

    localparam logic [1:0] c_stIdle  = 2'd0;
    localparam logic [1:0] c_stCalc  = 2'd1;
    localparam logic [1:0] c_stFix   = 2'd2;

    localparam logic       c_modeMul = 1'b0;
    localparam logic       c_modeDiv = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_step
// Description : One radix-2 iteration: shift-add multiply or restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_step
    import mdu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 i_mode,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_operand,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_remShift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Divide keeps {remainder, dividend/quotient}; the remainder never exceeds
    // the divisor, so only its low WIDTH bits of the difference matter.
    always_comb begin
        w_mulSum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                   + (i_acc[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});
        w_remShift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_ge       = (w_remShift >= {1'b0, i_operand});
        w_diff     = w_remShift[WIDTH-1:0] - i_operand;
        if (i_mode == c_modeDiv) begin
            o_acc = {(w_ge ? w_diff : w_remShift[WIDTH-1:0]), i_acc[WIDTH-2:0], w_ge};
        end else begin
            o_acc = {w_mulSum, i_acc[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative MIPS-style multiply/divide unit with HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mdu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]           r_state;
    logic [1:0]           w_nextState;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_stepAcc;
    logic [WIDTH-1:0]     r_operand;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_isDiv;
    logic                 r_negMain;
    logic                 r_negRem;
    logic                 r_zeroDiv;
    logic                 r_done;
    logic                 r_div0;

    logic                 w_accept;
    logic                 w_longOp;
    logic                 w_signedOp;
    logic                 w_signA;
    logic                 w_signB;
    logic [WIDTH-1:0]     w_magA;
    logic [WIDTH-1:0]     w_magB;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    always_comb begin
        w_accept   = (r_state == c_stIdle) && start && !flush;
        w_longOp   = (op == c_opMult) || (op == c_opMultu) || (op == c_opDiv) || (op == c_opDivu);
        w_signedOp = (op == c_opMult) || (op == c_opDiv);
        w_signA    = w_signedOp && a[WIDTH-1];
        w_signB    = w_signedOp && b[WIDTH-1];
        w_magA     = w_signA ? -a : a;
        w_magB     = w_signB ? -b : b;
        w_prod     = r_negMain ? -r_acc : r_acc;
        w_quot     = r_negMain ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem      = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    mdu_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_mode    (r_isDiv ? c_modeDiv : c_modeMul),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_stepAcc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_stIdle;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_stIdle: if (w_accept && w_longOp) w_nextState = c_stCalc;
            c_stCalc: begin
                if (flush)              w_nextState = c_stIdle;
                else if (r_cnt == '0)   w_nextState = c_stFix;
            end
            c_stFix:  w_nextState = c_stIdle;
            default:  w_nextState = c_stIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_isDiv   <= 1'b0;
            r_negMain <= 1'b0;
            r_negRem  <= 1'b0;
            r_zeroDiv <= 1'b0;
            r_done    <= 1'b0;
            r_div0    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                c_stIdle: begin
                    if (w_accept && w_longOp) begin
                        r_acc     <= {{WIDTH{1'b0}}, w_magA};
                        r_operand <= w_magB;
                        r_cnt     <= CNT_W'(WIDTH - 1);
                        r_isDiv   <= (op == c_opDiv) || (op == c_opDivu);
                        r_negMain <= w_signA ^ w_signB;
                        r_negRem  <= w_signA;
                        r_zeroDiv <= (b == '0);
                    end else if (w_accept && op == c_opMthi) begin
                        r_hi <= a;
                    end else if (w_accept && op == c_opMtlo) begin
                        r_lo <= a;
                    end
                end
                c_stCalc: begin
                    if (!flush) begin
                        r_acc <= w_stepAcc;
                        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_stFix: begin
                    // A zero divisor completes normally but leaves HI/LO intact.
                    if (!flush) begin
                        r_done <= 1'b1;
                        r_div0 <= r_isDiv && r_zeroDiv;
                        if (!r_isDiv) begin
                            {r_hi, r_lo} <= w_prod;
                        end else if (!r_zeroDiv) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != c_stIdle);
    assign done = r_done;
    assign div0 = r_div0;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench: directed vector table, corner sequences,
//               and random operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int nErr;
    int nChecks;
    logic [31:0] mHi;
    logic [31:0] mLo;
    logic        mDiv0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eHi;
        logic [31:0] eLo;
        logic        eDiv0;
    } vec_t;

    vec_t vecs[14];

    mul_div_unit #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the architectural state.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] p;
        logic signed [63:0] q;
        logic signed [63:0] r;
        mDiv0 = 1'b0;
        case (o)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                {mHi, mLo} = p;
            end
            3'd1: {mHi, mLo} = {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 32'd0) mDiv0 = 1'b1;
                else begin
                    q = longint'($signed(x)) / longint'($signed(y));
                    r = longint'($signed(x)) % longint'($signed(y));
                    mLo = q[31:0];
                    mHi = r[31:0];
                end
            end
            3'd3: begin
                if (y == 32'd0) mDiv0 = 1'b1;
                else begin
                    mLo = x / y;
                    mHi = x % y;
                end
            end
            3'd4: mHi = x;
            3'd5: mLo = x;
            default: ;
        endcase
    endtask

    // Starts at a negedge with the unit idle; returns at a negedge with it idle.
    task automatic runOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eHi, input logic [31:0] eLo, input logic eDiv0,
                         input string tag);
        int cyc;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (o <= 3'd3) begin
            cyc = 0;
            while (busy && cyc < 100) begin
                cyc++;
                @(negedge clk);
            end
            chk({tag, " busyCycles"}, 64'(cyc), 64'd33);
            chk({tag, " done"}, 64'(done), 64'd1);
            chk({tag, " div0"}, 64'(div0), 64'(eDiv0));
            chk({tag, " hi"}, 64'(hi), 64'(eHi));
            chk({tag, " lo"}, 64'(lo), 64'(eLo));
            @(negedge clk);
            chk({tag, " donePulse"}, {62'd0, done, div0}, 64'd0);
        end else begin
            chk({tag, " idleOp"}, {62'd0, busy, done}, 64'd0);
            chk({tag, " hi"}, 64'(hi), 64'(eHi));
            chk({tag, " lo"}, 64'(lo), 64'(eLo));
        end
    endtask

    task automatic noDoneFor(input int n, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (done || div0) seen++;
            @(negedge clk);
        end
        chk({tag, " noDone"}, 64'(seen), 64'd0);
    endtask

    initial begin
        int cyc;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        nErr    = 0;
        nChecks = 0;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h80000000, 1'b0};
        vecs[5]  = '{3'd3, 32'd100,      32'd0,        32'h12345678, 32'h80000000, 1'b1};
        vecs[6]  = '{3'd5, 32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 1'b0};
        vecs[7]  = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{3'd6, 32'hDEADBEEF, 32'd1,        32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[11] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[12] = '{3'd2, 32'd0,        32'd5,        32'h00000000, 32'h00000000, 1'b0};
        vecs[13] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'h00000000, 32'h00000000, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset outputs", {29'd0, busy, done, div0, hi}, 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eHi, vecs[i].eLo,
                  vecs[i].eDiv0, $sformatf("vec%0d", i));
        end

        // Second start and flush during a divide.
        runOp(3'd4, 32'h11111111, 32'd0, 32'h11111111, 32'h00000000, 1'b0, "setHi");
        runOp(3'd5, 32'h22222222, 32'd0, 32'h11111111, 32'h22222222, 1'b0, "setLo");
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (k == 5) begin
                start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy before flush", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("busy after flush", 64'(busy), 64'd0);
        noDoneFor(40, "flush");
        chk("flush hi", 64'(hi), 64'h11111111);
        chk("flush lo", 64'(lo), 64'h22222222);

        // Flush while idle must block even MTLO.
        start = 1'b1; op = 3'd5; a = 32'h55555555; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle flush blocks", {31'd0, busy, lo}, 64'h22222222);

        // Reset in the middle of a multiply.
        start = 1'b1; op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midReset busy", 64'(busy), 64'd0);
        chk("midReset hilo", {hi, lo}, 64'd0);
        noDoneFor(40, "midReset");

        // Start accepted in the same cycle done is high.
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin cyc++; @(negedge clk); end
        chk("b2b first done", 64'(done), 64'd1);
        chk("b2b first result", {hi, lo}, 64'd15);
        start = 1'b1; op = 3'd3; a = 32'd15; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        chk("b2b accepted", {62'd0, busy, done}, 64'd2);
        cyc = 0;
        while (busy && cyc < 100) begin cyc++; @(negedge clk); end
        chk("b2b second done", 64'(done), 64'd1);
        chk("b2b second result", {hi, lo}, {32'd3, 32'd3});
        @(negedge clk);

        // Random operations against the reference model.
        mHi = hi === 32'd3 ? 32'd3 : 32'd3;
        mLo = 32'd3;
        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h80000000;
                3: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            model(ro, ra, rb);
            runOp(ro, ra, rb, mHi, mLo, mDiv0, $sformatf("rnd%0d op%0d", n, ro));
        end

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
